// File: rtl/sumador_serial_pkg.sv
// rtl/sumador_serial_pkg.sv - shared state type and default width for the serial adder
package sumador_pkg;

  localparam int SUMADOR_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/sumador_serial_if.sv
// rtl/sumador_serial_if.sv - start/operand/result bundle of the serial adder (ovf under SUMADOR_OVERFLOW_EN)
interface sumador_serial_if
  import sumador_pkg::*;
#(
  parameter int WIDTH = SUMADOR_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carri_out;
`ifdef SUMADOR_OVERFLOW_EN
  logic             ovf;
`endif

  // Requester side: issues operands, observes status and result
  modport master (
    output start, a, b,
    input  ready, busy, done, sum, carri_out
`ifdef SUMADOR_OVERFLOW_EN
    , input ovf
`endif
  );

  // Adder side
  modport slave (
    input  start, a, b,
    output ready, busy, done, sum, carri_out
`ifdef SUMADOR_OVERFLOW_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/sumador_serial_completo.sv
// rtl/sumador_serial_completo.sv - 1-bit full adder used once per serial step
module sumador_completo (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serial.sv
// rtl/sumador_serial.sv - LSB-first bit-serial adder, one bit per clock; SUMADOR_OVERFLOW_EN adds signed ovf output
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int WIDTH = SUMADOR_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  sumador_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_q, state_d;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] ra_q, rb_q;
  // Holds the result bits collected so far; the final bit completes it
  logic [WIDTH-2:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic             carry_q;
  logic [CW-1:0]    count_q;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic             fa_s, fa_c;

`ifdef SUMADOR_OVERFLOW_EN
  logic             a_msb_q, b_msb_q;
  logic             ovf_q;
`endif

  sumador_completo u_fa (
    .a    (ra_q[0]),
    .b    (rb_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_c)
  );

  assign last_bit = (count_q == CW'(WIDTH - 1));
  assign acc_d    = {fa_s, acc_q};

  // Next-state logic; new operands are taken only from IDLE or FIN
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SUMA;
        end
      end
      SUMA: begin
        if (last_bit) state_d = FIN;
      end
      FIN: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = SUMA;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand shifters, carry/count and the result register, which loads only on the last bit
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      count_q <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SUMADOR_OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else if (accept) begin
      ra_q    <= bus.a;
      rb_q    <= bus.b;
      carry_q <= 1'b0;
      count_q <= '0;
`ifdef SUMADOR_OVERFLOW_EN
      a_msb_q <= bus.a[WIDTH-1];
      b_msb_q <= bus.b[WIDTH-1];
`endif
    end else if (state_q == SUMA) begin
      ra_q    <= {1'b0, ra_q[WIDTH-1:1]};
      rb_q    <= {1'b0, rb_q[WIDTH-1:1]};
      acc_q   <= acc_d[WIDTH-1:1];
      carry_q <= fa_c;
      count_q <= count_q + CW'(1);
      if (last_bit) begin
        sum_q  <= acc_d;
        cout_q <= fa_c;
`ifdef SUMADOR_OVERFLOW_EN
        ovf_q  <= (a_msb_q == b_msb_q) && (fa_s != a_msb_q);
`endif
      end
    end
  end

  assign bus.ready     = (state_q == IDLE) || (state_q == FIN);
  assign bus.busy      = (state_q == SUMA);
  assign bus.done      = (state_q == FIN);
  assign bus.sum       = sum_q;
  assign bus.carri_out = cout_q;
`ifdef SUMADOR_OVERFLOW_EN
  assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_sumador_serial.sv
// tb/tb_sumador_serial.sv - randomized self-checking bench for sumador_serial against an arithmetic model
module tb_sumador_serial;
  import sumador_pkg::*;

  localparam int W   = SUMADOR_WIDTH;
  localparam int LAT = W + 1;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sumador_serial_if #(.WIDTH(W)) bus ();

  sumador_serial #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [W-1:0] model_sum(input int x, input int y);
    return W'((x + y) % (1 << W));
  endfunction

  function automatic logic model_cout(input int x, input int y);
    return (x + y) >= (1 << W);
  endfunction

  function automatic logic model_ovf(input int x, input int y);
    int sx, sy, s;
    sx = (x >= (1 << (W - 1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W - 1))) ? y - (1 << W) : y;
    s  = sx + sy;
    return (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)));
  endfunction

  // Issues one operation and waits for done; noise scribbles on start/a/b while busy
  task automatic run_op(input int ai, input int bi, input bit noise,
                        output logic [W-1:0] s, output logic c, output logic o, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = W'(ai);
    bus.b     = W'(bi);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (bus.done === 1'b1 || lat >= 20) break;
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    s = bus.sum;
    c = bus.carri_out;
`ifdef SUMADOR_OVERFLOW_EN
    o = bus.ovf;
`else
    o = 1'b0;
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    checks += 5;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    if (bus.sum !== '0) begin errors++; $display("FAIL reset_sum: got %0d expected 0", bus.sum); end
    if (bus.carri_out !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.carri_out); end
`ifdef SUMADOR_OVERFLOW_EN
    checks++;
    if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(7);
    bus.b = W'(5);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.a = W'($urandom);
      bus.b = W'($urandom);
      checks += 3;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy c%0d: got %b expected 1", i, bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_early_done c%0d: got %b expected 0", i, bus.done); end
      if (bus.sum !== '0) begin errors++; $display("FAIL basic_sum_stable c%0d: got %0d expected 0", i, bus.sum); end
    end
    @(negedge clk);
    checks += 5;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b expected 1", bus.done); end
    if (bus.sum !== W'(12)) begin errors++; $display("FAIL basic_sum: got %0d expected 12", bus.sum); end
    if (bus.carri_out !== 1'b0) begin errors++; $display("FAIL basic_cout: got %b expected 0", bus.carri_out); end
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL basic_ready_fin: got %b expected 1", bus.ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_fin: got %b expected 0", bus.busy); end
    @(negedge clk);
    checks += 3;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL basic_done_drop: got %b expected 0", bus.done); end
    if (bus.sum !== W'(12)) begin errors++; $display("FAIL basic_sum_held: got %0d expected 12", bus.sum); end
    if (bus.carri_out !== 1'b0) begin errors++; $display("FAIL basic_cout_held: got %b expected 0", bus.carri_out); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] s; logic c, o; int lat;
    run_op(15, 1, 1'b0, s, c, o, lat);
    checks += 3;
    if (lat !== LAT) begin errors++; $display("FAIL wrap_latency: got %0d expected %0d", lat, LAT); end
    if (s !== '0) begin errors++; $display("FAIL wrap_sum: got %0d expected 0", s); end
    if (c !== 1'b1) begin errors++; $display("FAIL wrap_cout: got %b expected 1", c); end
  endtask

  task automatic test_inverse_sweep();
    logic [W-1:0] s; logic c, o; int lat;
    run_op(7, 3, 1'b0, s, c, o, lat);
    checks += 2;
    if (s !== W'(10)) begin errors++; $display("FAIL inverse_sum: got %0d expected 10", s); end
    if (c !== 1'b0) begin errors++; $display("FAIL inverse_cout: got %b expected 0", c); end
    for (int x = 0; x < (1 << W); x++) begin
      for (int y = 0; y < (1 << W); y++) begin
        run_op(x, y, 1'b0, s, c, o, lat);
        checks += 3;
        if (lat !== LAT) begin errors++; $display("FAIL sweep_latency %0d+%0d: got %0d expected %0d", x, y, lat, LAT); end
        if (s !== model_sum(x, y)) begin errors++; $display("FAIL sweep_sum %0d+%0d: got %0d expected %0d", x, y, s, model_sum(x, y)); end
        if (c !== model_cout(x, y)) begin errors++; $display("FAIL sweep_cout %0d+%0d: got %b expected %b", x, y, c, model_cout(x, y)); end
`ifdef SUMADOR_OVERFLOW_EN
        checks++;
        if (o !== model_ovf(x, y)) begin errors++; $display("FAIL sweep_ovf %0d+%0d: got %b expected %b", x, y, o, model_ovf(x, y)); end
`endif
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(2);
    bus.b = W'(3);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      if (i == 1) begin bus.a = W'(9); bus.b = W'(9); end
      checks += 2;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy1 c%0d: got %b expected 1", i, bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done1 c%0d: got %b expected 0", i, bus.done); end
    end
    @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_first_done: got %b expected 1", bus.done); end
    if (bus.sum !== model_sum(2, 3)) begin errors++; $display("FAIL b2b_first_sum: got %0d expected %0d", bus.sum, model_sum(2, 3)); end
    bus.a = W'(4);
    bus.b = W'(4);
    for (int i = 1; i <= W; i++) begin
      @(negedge clk);
      checks += 3;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_busy2 c%0d: got %b expected 1", i, bus.busy); end
      if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done2 c%0d: got %b expected 0", i, bus.done); end
      if (bus.sum !== model_sum(2, 3)) begin errors++; $display("FAIL b2b_hold c%0d: got %0d expected %0d", i, bus.sum, model_sum(2, 3)); end
    end
    @(negedge clk);
    bus.start = 1'b0;
    checks += 2;
    if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b expected 1", bus.done); end
    if (bus.sum !== model_sum(4, 4)) begin errors++; $display("FAIL b2b_second_sum: got %0d expected %0d", bus.sum, model_sum(4, 4)); end
    @(negedge clk);
    checks += 2;
    if (bus.done !== 1'b0) begin errors++; $display("FAIL b2b_done_drop: got %b expected 0", bus.done); end
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b expected 1", bus.ready); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a = W'(9);
    bus.b = W'(9);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 5;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", bus.busy); end
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b expected 1", bus.ready); end
    if (bus.done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b expected 0", bus.done); end
    if (bus.sum !== '0) begin errors++; $display("FAIL rstmid_sum: got %0d expected 0", bus.sum); end
    if (bus.carri_out !== 1'b0) begin errors++; $display("FAIL rstmid_cout: got %b expected 0", bus.carri_out); end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_random();
    logic [W-1:0] s; logic c, o; int lat, x, y;
    for (int n = 0; n < 60; n++) begin
      x = int'($urandom_range(0, (1 << W) - 1));
      y = int'($urandom_range(0, (1 << W) - 1));
      run_op(x, y, 1'b1, s, c, o, lat);
      checks += 3;
      if (lat !== LAT) begin errors++; $display("FAIL rand_latency %0d+%0d: got %0d expected %0d", x, y, lat, LAT); end
      if (s !== model_sum(x, y)) begin errors++; $display("FAIL rand_sum %0d+%0d: got %0d expected %0d", x, y, s, model_sum(x, y)); end
      if (c !== model_cout(x, y)) begin errors++; $display("FAIL rand_cout %0d+%0d: got %b expected %b", x, y, c, model_cout(x, y)); end
    end
  endtask

`ifdef SUMADOR_OVERFLOW_EN
  task automatic test_ovf();
    logic [W-1:0] s; logic c, o; int lat;
    run_op(7, 1, 1'b0, s, c, o, lat);
    checks += 2;
    if (s !== W'(8)) begin errors++; $display("FAIL ovf_7p1_sum: got %0d expected 8", s); end
    if (o !== 1'b1) begin errors++; $display("FAIL ovf_7p1_ovf: got %b expected 1", o); end
    run_op(8, 8, 1'b0, s, c, o, lat);
    checks += 3;
    if (s !== '0) begin errors++; $display("FAIL ovf_8p8_sum: got %0d expected 0", s); end
    if (c !== 1'b1) begin errors++; $display("FAIL ovf_8p8_cout: got %b expected 1", c); end
    if (o !== 1'b1) begin errors++; $display("FAIL ovf_8p8_ovf: got %b expected 1", o); end
    run_op(3, 2, 1'b0, s, c, o, lat);
    checks++;
    if (o !== 1'b0) begin errors++; $display("FAIL ovf_3p2_ovf: got %b expected 0", o); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_inverse_sweep();
    test_back_to_back();
    test_reset_mid();
    test_random();
`ifdef SUMADOR_OVERFLOW_EN
    test_ovf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
